bram_writer: RTL and testbench
==============================

BRAM_WRITER -- requirements
Module: bram_writer

Interface
REQ-001 Parameter ADDR_W, default 4: BRAM address width.
REQ-002 Parameter DATA_W, default 4: BRAM data width; matches the LED-side reader's data width.
REQ-003 Parameter DEPTH, default 16: words written by a fill; DEPTH <= 2^ADDR_W.
REQ-004 Parameter DEBOUNCE_CYCLES, default 1_000_000: stable cycles a button level needs before it is accepted; minimum 1.
REQ-005 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port btn, input, 4: raw, asynchronous push-buttons.
REQ-008 Port data_in, input, DATA_W: word written by a button write (switches).
REQ-009 Port fill_start, input, 1: synchronous request to fill addresses 0..DEPTH-1.
REQ-010 Port bram_en, output, 1: BRAM port-A enable.
REQ-011 Port bram_we, output, 1: BRAM port-A write enable.
REQ-012 Port bram_addr, output, ADDR_W: BRAM port-A address.
REQ-013 Port bram_din, output, DATA_W: BRAM port-A write data.
REQ-014 Port busy, output, 1: high while a fill is in progress.
REQ-015 Port done, output, 1: one-cycle pulse when a fill completes.
REQ-016 Port wr_count, output, 8: total writes issued, saturating.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 Each btn bit SHALL pass through a 2-FF synchronizer.
- After that, a per-bit debouncer: the debounced level takes the synchronized value only after it has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
- Any return to the old level restarts the count.
REQ-019 A rising edge of a debounced level SHALL produce a one-cycle press pulse for that bit.
REQ-020 The FSM SHALL have exactly the states IDLE, WRITE, FILL and DONE, with the following transitions:
- IDLE->FILL: fill_start is high.
- IDLE->WRITE: exactly one press pulse is active and fill_start is low.
- WRITE->IDLE: after one cycle.
- FILL->DONE: after the write to address DEPTH-1.
- DONE->IDLE: after one cycle.
REQ-021 In WRITE the outputs SHALL be:
- bram_en=1 and bram_we=1 for exactly one cycle.
- bram_addr = index of the pressed bit (btn[0]->0, btn[1]->1, btn[2]->2, btn[3]->3).
- bram_din = data_in as sampled in the IDLE cycle that saw the press.
REQ-022 Timing: bram_we SHALL assert on the cycle after the press pulse. For a fill, the first write SHALL occur the cycle after fill_start is sampled.
REQ-023 In FILL the block SHALL issue one write per cycle, back-to-back:
- Addresses 0,1,...,DEPTH-1.
- bram_din = address modulo 2^DATA_W.
- busy=1 from the first write through the last write.
REQ-024 In DONE: done=1 for one cycle, busy=0, bram_en=0, bram_we=0.
REQ-025 Outside write cycles: bram_en=0 and bram_we=0; bram_addr and bram_din hold their last values.
REQ-026 Conflict and drop rules:
- Two or more simultaneous press pulses SHALL be ignored (no write).
- fill_start and a press pulse in the same IDLE cycle: the fill wins and the press is dropped.
- Press pulses and fill_start arriving in WRITE, FILL or DONE SHALL be dropped, not queued.
REQ-027 wr_count SHALL increment by 1 on every cycle with bram_we=1 and saturate at 255.

Reset
REQ-028 When rst_n=0, the block SHALL immediately enter and hold the following state:
- FSM in IDLE.
- bram_en, bram_we, bram_addr, bram_din, busy, done and wr_count all 0.
- Synchronizers, debounced levels and debounce counters all 0.
REQ-029 Reset asserted mid-fill SHALL abort the fill:
- No done pulse.
- No further writes after rst_n is released until a new fill_start.
REQ-030 Reset release SHALL be synchronized internally. The first state change SHALL occur no earlier than the second rising clk edge after rst_n rises.

Verification (DEBOUNCE_CYCLES=4, DEPTH=16)
REQ-031 Button write: data_in=0xA, btn=0100 held 10 cycles -> exactly one write with bram_addr=2, bram_din=0xA, wr_count=1.
REQ-032 Bounce: btn[1] toggles every 2 cycles for 20 cycles, then returns low -> no write; wr_count=0.
REQ-033 Fill: one-cycle fill_start -> 16 consecutive writes, addr 0..15 with din=addr, busy high for 16 cycles, then done high for 1 cycle, wr_count=16.
REQ-034 Conflicts:
- fill_start coincident with a btn[0] press pulse -> fill only, no address-0 button write.
- btn=0011 pressed together -> no write.
REQ-035 Reset mid-fill: rst_n low after the write to address 5 -> all outputs 0, no done. A later fill_start -> full 16-write fill; wr_count restarts from 0.
REQ-036 Saturation: 17 fills -> wr_count holds at 255.

Source files
------------

// File: rtl/bram_writer.sv
// Button/fill driven BRAM port-A writer: debounced push-buttons write a switch word to
// addresses 0..3, and fill_start writes address pattern 0..DEPTH-1 back-to-back.
module bram_writer #(
  parameter int ADDR_W          = 4,
  parameter int DATA_W          = 4,
  parameter int DEPTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        btn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fill_start,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              busy,
  output logic              done,
  output logic [7:0]        wr_count
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

  state_t            state, state_n;
  logic [1:0]        rst_sync;
  logic              run;
  logic [3:0]        sync1, sync2, deb, deb_d, press;
  logic [CNT_W-1:0]  cnt [4];
  logic [1:0]        press_idx;
  logic              single_press;
  logic              en_n, we_n, busy_n, done_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] din_n;

  // Reset release is retimed; run only rises after reset, so "hold while !run" equals "hold reset values".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  always_comb run = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (run) begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_d <= deb;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i] <= '0;
          deb[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press     = deb & ~deb_d;
    press_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (press[i]) press_idx = 2'(i);
    end
    single_press = ($countones(press) == 1);
  end

  // Next-state logic also produces next-cycle output values so every output is a flop.
  always_comb begin
    state_n = state;
    en_n    = 1'b0;
    we_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    addr_n  = bram_addr;
    din_n   = bram_din;
    unique case (state)
      IDLE: begin
        if (fill_start) begin
          state_n = FILL;
          en_n    = 1'b1;
          we_n    = 1'b1;
          busy_n  = 1'b1;
          addr_n  = '0;
          din_n   = '0;
        end else if (single_press) begin
          state_n = WRITE;
          en_n    = 1'b1;
          we_n    = 1'b1;
          addr_n  = ADDR_W'(press_idx);
          din_n   = data_in;
        end
      end
      WRITE: state_n = IDLE;
      FILL: begin
        if (bram_addr == LAST_ADDR) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          en_n   = 1'b1;
          we_n   = 1'b1;
          busy_n = 1'b1;
          addr_n = bram_addr + 1'b1;
          din_n  = DATA_W'(addr_n);
        end
      end
      DONE: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_count  <= '0;
    end else if (run) begin
      state     <= state_n;
      bram_en   <= en_n;
      bram_we   <= we_n;
      bram_addr <= addr_n;
      bram_din  <= din_n;
      busy      <= busy_n;
      done      <= done_n;
      if (we_n && wr_count != 8'd255) wr_count <= wr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_bram_writer.sv
// Self-checking bench for bram_writer: directed vector table, corner-case sequences and
// randomized button/fill operations scored against a transaction-level write model.
module tb_bram_writer;
  localparam int AW = 4, DW = 4, DEPTH = 16, DEB = 4;

  logic          clk = 1'b0, rst_n = 1'b0, fill_start = 1'b0;
  logic [3:0]    btn = '0;
  logic [DW-1:0] data_in = '0;
  logic          bram_en, bram_we, busy, done;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [7:0]    wr_count;

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] din;} wr_t;
  typedef struct {
    logic [3:0] btn; logic [3:0] data; bit fill; int nwr; logic [3:0] addr; logic [3:0] din;
  } vec_t;

  int   tests = 0, fails = 0;
  int   done_cnt = 0, busy_cnt = 0, exp_total = 0;
  wr_t  got[$];
  wr_t  expq[$];
  vec_t vt[8];

  bram_writer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .data_in(data_in), .fill_start(fill_start),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bram_we) got.push_back({bram_addr, bram_din});
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_writes(input string name, input wr_t exp[$]);
    chk({name, " count"}, got.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got.size(); k++) begin
      tests++;
      if (got[k] !== exp[k]) begin
        fails++;
        $display("FAIL %s write%0d: got addr=%0h din=%0h expected addr=%0h din=%0h",
                 name, k, got[k].addr, got[k].din, exp[k].addr, exp[k].din);
      end
    end
  endtask

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear();
    got.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic press(input logic [3:0] p, input logic [3:0] d);
    data_in = d;
    btn = p;
    cyc(10);
    btn = '0;
    cyc(12);
  endtask

  task automatic do_fill();
    fill_start = 1'b1;
    cyc(1);
    fill_start = 1'b0;
    cyc(DEPTH + 4);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " en"}, bram_en, 0);
    chk({name, " we"}, bram_we, 0);
    chk({name, " addr"}, bram_addr, 0);
    chk({name, " din"}, bram_din, 0);
    chk({name, " busy"}, busy, 0);
    chk({name, " done"}, done, 0);
    chk({name, " wr_count"}, wr_count, 0);
  endtask

  initial begin
    vt[0] = '{4'b0100, 4'hA, 1'b0, 1, 4'd2, 4'hA};
    vt[1] = '{4'b0001, 4'h3, 1'b0, 1, 4'd0, 4'h3};
    vt[2] = '{4'b0010, 4'hC, 1'b0, 1, 4'd1, 4'hC};
    vt[3] = '{4'b1000, 4'h5, 1'b0, 1, 4'd3, 4'h5};
    vt[4] = '{4'b0011, 4'h7, 1'b0, 0, 4'd0, 4'h0};
    vt[5] = '{4'b1111, 4'h9, 1'b0, 0, 4'd0, 4'h0};
    vt[6] = '{4'b0000, 4'h0, 1'b1, 16, 4'd0, 4'h0};
    vt[7] = '{4'b0110, 4'h1, 1'b0, 0, 4'd0, 4'h0};

    // Reset state
    cyc(3);
    #1 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    cyc(4);
    chk_zero("post-release");

    // Directed table
    foreach (vt[i]) begin
      clear();
      expq.delete();
      if (vt[i].fill) begin
        do_fill();
        for (int k = 0; k < DEPTH; k++) expq.push_back({AW'(k), DW'(k)});
        chk($sformatf("vec%0d busy cycles", i), busy_cnt, DEPTH);
        chk($sformatf("vec%0d done pulses", i), done_cnt, 1);
      end else begin
        press(vt[i].btn, vt[i].data);
        if (vt[i].nwr == 1) expq.push_back({vt[i].addr, vt[i].din});
      end
      chk_writes($sformatf("vec%0d", i), expq);
      exp_total += vt[i].nwr;
      chk($sformatf("vec%0d wr_count", i), wr_count, sat(exp_total));
    end

    // Bounce on btn[1]: pulses shorter than the debounce window never write
    clear();
    repeat (5) begin
      btn[1] = 1'b1; cyc(2);
      btn[1] = 1'b0; cyc(2);
    end
    cyc(12);
    chk("bounce writes", got.size(), 0);
    chk("bounce wr_count", wr_count, sat(exp_total));

    // fill_start exactly coincident with btn[0] press pulse (press pulse lies between edges 6 and 7)
    clear();
    data_in = 4'hF;
    btn = 4'b0001;
    cyc(6);
    fill_start = 1'b1;
    cyc(1);
    fill_start = 1'b0;
    chk("fill latency we", bram_we, 1);
    chk("fill latency addr", bram_addr, 0);
    chk("fill latency busy", busy, 1);
    cyc(DEPTH + 4);
    btn = '0;
    cyc(12);
    expq.delete();
    for (int k = 0; k < DEPTH; k++) expq.push_back({AW'(k), DW'(k)});
    chk_writes("conflict", expq);
    exp_total += DEPTH;
    chk("conflict wr_count", wr_count, sat(exp_total));

    // Randomized operations against a transaction-level model
    clear();
    expq.delete();
    for (int n = 0; n < 30; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        int unsigned b;
        logic [3:0] d;
        b = $urandom_range(0, 3);
        d = 4'($urandom_range(0, 15));
        press(4'b0001 << b, d);
        expq.push_back({AW'(b), d});
        exp_total++;
      end else if (r < 7) begin
        logic [3:0] p;
        do p = 4'($urandom_range(0, 15)); while ($countones(p) < 2);
        press(p, 4'($urandom_range(0, 15)));
      end else if (r < 8) begin
        int unsigned b;
        b = $urandom_range(0, 3);
        repeat (4) begin
          btn[b] = 1'b1; cyc(2);
          btn[b] = 1'b0; cyc(2);
        end
        cyc(12);
      end else begin
        do_fill();
        for (int k = 0; k < DEPTH; k++) expq.push_back({AW'(k), DW'(k)});
        exp_total += DEPTH;
      end
    end
    chk_writes("random", expq);
    chk("random wr_count", wr_count, sat(exp_total));

    // Reset release: nothing changes before the second edge after rst_n rises
    @(negedge clk) rst_n = 1'b0;
    fill_start = 1'b1;
    #1 clear();
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("release edge1 we", bram_we, 0);
    cyc(1);
    chk("release edge2 we", bram_we, 0);
    chk("release edge2 busy", busy, 0);
    cyc(1);
    fill_start = 1'b0;
    cyc(DEPTH + 6);
    chk("release fill writes", got.size(), DEPTH);
    exp_total = DEPTH;
    chk("release wr_count", wr_count, exp_total);

    // Reset mid-fill after the write to address 5
    begin
      bit found;
      found = 1'b0;
      fill_start = 1'b1;
      cyc(1);
      fill_start = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
        if (bram_we && bram_addr == 5) found = 1'b1;
        else cyc(1);
      end
      chk("midfill reached addr5", found, 1);
      rst_n = 1'b0;
      #1 chk_zero("midfill reset");
      cyc(2);
      rst_n = 1'b1;
      clear();
      cyc(30);
      chk("midfill no writes", got.size(), 0);
      chk("midfill no done", done_cnt, 0);
      chk("midfill wr_count", wr_count, 0);
      do_fill();
      chk("refill writes", got.size(), DEPTH);
      chk("refill done", done_cnt, 1);
      chk("refill wr_count", wr_count, DEPTH);
      exp_total = DEPTH;
    end

    // Saturation
    repeat (17) do_fill();
    exp_total += 17 * DEPTH;
    chk("saturate wr_count", wr_count, sat(exp_total));
    press(4'b0100, 4'h6);
    chk("saturate hold", wr_count, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
